mem_stage: RTL and testbench
============================

# mem_stage

Fourth stage of the five-stage MIPS pipeline, between the execute stage and the write-back stage. It registers the execute-stage payload and takes the synchronous data-SRAM read data one cycle after the execute stage issued the address. A holding buffer keeps that read data if the write-back stage stalls. The stage forms the final GPR result and forwards exception status upstream, so the execute stage can suppress stores behind an excepting instruction. Optionally it drives a forwarding bus to decode.

## Interface

Parameters:
- ES_TO_MS_BUS_WD, 116, execute→memory payload width
- MS_TO_WS_BUS_WD, 115, memory→write-back payload width
- MS_TO_DS_BUS_WD, 39, forwarding bus width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  write-back can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute payload valid
- es_to_ms_bus  in  116  {mtc0_we[115], cp0_addr[114:110], ex[109], excode[108:104], res_from_cp0[103], res_from_mem[102], gr_we[101], dest[100:96], alu_result[95:64], rt_value[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  payload to write-back valid
- ms_to_ws_bus  out  115  {mtc0_we, cp0_addr, ex, excode, res_from_cp0, gr_we, dest, final_result, rt_value, pc}
- ms_to_es_bus  out  1  ex_from_cur_ms = ms_valid & ms_ex
- ws_flush  in  1  exception/eret committed in write-back; kill this stage
- data_sram_rdata  in  32  synchronous SRAM read data
- ms_to_ds_bus  out  39  {fwd_we, fwd_is_cp0, fwd_dest[4:0], fwd_result[31:0]}

## Operation

Valid and payload handshake:
- ms_ready_go = 1.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- On the clock edge, priority order:
  - reset → ms_valid = 0
  - else ws_flush → ms_valid = 0
  - else ms_allowin → ms_valid = es_to_ms_valid
- The payload register loads only when es_to_ms_valid & ms_allowin & !ws_flush.

Read-data holding buffer:
- ms_first is set when a payload is accepted. It clears on the next edge.
- When ms_valid & ms_first & !ws_allowin, capture data_sram_rdata into rbuf and set rbuf_valid = 1.
- rbuf_valid clears on any of: reset, ws_flush, or retirement (ms_to_ws_valid & ws_allowin).
- Load data = rbuf_valid ? rbuf : data_sram_rdata.

Result and gating:
- final_result = res_from_mem ? load data : alu_result. cp0 reads are resolved in write-back.
- Outgoing gr_we = gr_we & !ex.
- Outgoing mtc0_we = mtc0_we & !ex.
- ex and excode pass through unchanged. excode is don't-care when ex = 0.
- ms_to_es_bus = ms_valid & ex. It is deasserted during a ws_flush cycle only once ms_valid falls (the next edge).

## Timing

- Latency: 1 cycle from acceptance to ms_to_ws_valid.
- Throughput: 1 instruction per cycle.
- The SRAM read data is valid only in the first cycle of ms_valid. Later stall cycles use rbuf.
- Reset values: ms_valid, rbuf_valid and ms_first are 0. As a result ms_to_ws_valid = 0, ms_to_es_bus = 0, ms_allowin = 1 and ms_to_ds_bus = 0. Payload contents are don't-care.
- Flush and accept in the same cycle: the flush wins and the stage is empty next cycle.
- Stall longer than 1 cycle: rbuf holds its value and later SRAM data is ignored.
- Retire and accept in the same cycle: rbuf_valid clears and ms_first sets for the new instruction.

## Configuration

MS_FWD_EN:
- When defined, ms_to_ds_bus is driven as follows:
  - fwd_we = ms_valid & gr_we & !ex
  - fwd_is_cp0 = ms_valid & res_from_cp0 (decode must stall; the value is not available here)
  - fwd_dest = dest
  - fwd_result = final_result
- When undefined, the port remains and is tied to 0. Decode then relies on stall-only hazard handling.

## Test plan

- Back-to-back ALU ops with ws_allowin = 1: accept pc 0xBFC00000 and alu_result 0x5 → next cycle ms_to_ws_valid = 1 and final_result = 0x5. The following op is accepted in the same cycle.
- Load with a 3-cycle write-back stall: rdata 0xDEADBEEF in the first cycle, then 0x12345678 → final_result stays 0xDEADBEEF through the stall and at retirement.
- Exception passthrough: ex = 1, excode 0x04, gr_we = 1 → ms_to_es_bus = 1, outgoing gr_we = 0, excode = 0x04.
- Flush: ws_flush pulses while ms_valid = 1 and es_to_ms_valid = 1 → ms_valid = 0 and rbuf_valid = 0 next cycle. Nothing is forwarded.
- Reset mid-stall: set rbuf_valid, then assert reset → all outputs at their reset values. The first load after reset uses live rdata.
- MS_FWD_EN: in-flight load to dest 8 with rdata 0x7 → ms_to_ds_bus = {1, 0, 5'd8, 0x7}. For an mfc0 in flight, fwd_is_cp0 = 1.

Source files
------------

// File: rtl/mem_stage_if.sv
// +----------------------------------------------------------------------+
// | mem_stage_if : handshake and payload buses around the memory stage.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 116,
  parameter int MS_TO_WS_BUS_WD = 115,
  parameter int MS_TO_DS_BUS_WD = 39
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ms_to_es_bus;
  logic                       ws_flush;
  logic [31:0]                data_sram_rdata;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;

  // The memory stage itself.
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, ws_flush, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_es_bus, ms_to_ds_bus
  );

  // The surrounding pipeline (execute, write-back, data SRAM, decode).
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, ws_flush, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_es_bus, ms_to_ds_bus
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage : MIPS pipeline memory stage with SRAM read-data hold      |
// | buffer. Optional forwarding bus to decode when MS_FWD_EN is defined. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 116,
  parameter int MS_TO_WS_BUS_WD = 115,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mem_stage_if.slave      ms_if
);

  logic                       ms_valid_q,   ms_valid_d;
  logic                       ms_first_q,   ms_first_d;
  logic                       rbuf_valid_q, rbuf_valid_d;
  logic [31:0]                rbuf_q,       rbuf_d;
  logic [ES_TO_MS_BUS_WD-1:0] payload_q,    payload_d;

  logic        ms_ready_go;
  logic        accept;
  logic        retire;
  logic [31:0] load_data;
  logic [31:0] final_result;

  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic        ex;
  logic [4:0]  excode;
  logic        res_from_cp0;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] rt_value;
  logic [31:0] pc;

  assign ms_ready_go = 1'b1;
  assign ms_if.ms_allowin     = !ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid_q & ms_ready_go;

  assign accept = ms_if.es_to_ms_valid & ms_if.ms_allowin & !ms_if.ws_flush;
  assign retire = ms_if.ms_to_ws_valid & ms_if.ws_allowin;

  always_comb begin
    ms_valid_d   = ms_valid_q;
    payload_d    = payload_q;
    ms_first_d   = accept;
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;

    if (ms_if.ws_flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_if.ms_allowin) begin
      ms_valid_d = ms_if.es_to_ms_valid;
    end

    if (accept) begin
      payload_d = ms_if.es_to_ms_bus;
    end

    // SRAM data is only live in the first valid cycle; park it if WB stalls.
    if (ms_if.ws_flush | retire) begin
      rbuf_valid_d = 1'b0;
    end else if (ms_valid_q & ms_first_q & !ms_if.ws_allowin) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = ms_if.data_sram_rdata;
    end
  end

  // Payload is cleared on reset so the forwarding bus reads all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      ms_first_q   <= 1'b0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= 32'h0;
      payload_q    <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      ms_first_q   <= ms_first_d;
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_q       <= rbuf_d;
      payload_q    <= payload_d;
    end
  end

  assign mtc0_we      = payload_q[115];
  assign cp0_addr     = payload_q[114:110];
  assign ex           = payload_q[109];
  assign excode       = payload_q[108:104];
  assign res_from_cp0 = payload_q[103];
  assign res_from_mem = payload_q[102];
  assign gr_we        = payload_q[101];
  assign dest         = payload_q[100:96];
  assign alu_result   = payload_q[95:64];
  assign rt_value     = payload_q[63:32];
  assign pc           = payload_q[31:0];

  assign load_data    = rbuf_valid_q ? rbuf_q : ms_if.data_sram_rdata;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_if.ms_to_ws_bus = {mtc0_we & ~ex, cp0_addr, ex, excode, res_from_cp0,
                               gr_we & ~ex, dest, final_result, rt_value, pc};

  assign ms_if.ms_to_es_bus = ms_valid_q & ex;

`ifdef MS_FWD_EN
  // CP0 reads resolve in write-back, so decode must stall on fwd_is_cp0.
  assign ms_if.ms_to_ds_bus = {ms_valid_q & gr_we & ~ex, ms_valid_q & res_from_cp0,
                               dest, final_result};
`else
  assign ms_if.ms_to_ds_bus = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench for mem_stage.                        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  logic clk;
  logic reset;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [114:0] sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [115:0] mk_es(input logic mtc0, input logic [4:0] cp0a,
      input logic ex, input logic [4:0] exc, input logic rcp0, input logic rmem,
      input logic grwe, input logic [4:0] dst, input logic [31:0] alu,
      input logic [31:0] rt, input logic [31:0] pc);
    return {mtc0, cp0a, ex, exc, rcp0, rmem, grwe, dst, alu, rt, pc};
  endfunction

  function automatic logic [114:0] mk_ws(input logic mtc0, input logic [4:0] cp0a,
      input logic ex, input logic [4:0] exc, input logic rcp0, input logic grwe,
      input logic [4:0] dst, input logic [31:0] res, input logic [31:0] rt,
      input logic [31:0] pc);
    return {mtc0, cp0a, ex, exc, rcp0, grwe, dst, res, rt, pc};
  endfunction

  function automatic logic [38:0] mk_fwd(input logic we, input logic cp0,
      input logic [4:0] dst, input logic [31:0] res);
    logic [38:0] v;
    v = {we, cp0, dst, res};
`ifndef MS_FWD_EN
    v = '0;
`endif
    return v;
  endfunction

  // Monitor: every retirement pops one expected write-back payload.
  always @(negedge clk) begin
    if (!reset && ifc.ms_to_ws_valid && ifc.ws_allowin && !ifc.ws_flush) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_retire", {13'h0, ifc.ms_to_ws_bus}, 128'h0);
      end else begin
        chk("ws_bus", {13'h0, ifc.ms_to_ws_bus}, {13'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [115:0] es);
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = es;
  endtask

  task automatic issue(input logic [115:0] es, input logic [114:0] exp_ws);
    drive(es);
    sb_q.push_back(exp_ws);
  endtask

  task automatic idle;
    ifc.es_to_ms_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ms_to_ws_valid"}, {127'h0, ifc.ms_to_ws_valid}, 128'h0);
    chk({tag, "_ms_allowin"},     {127'h0, ifc.ms_allowin},     128'h1);
    chk({tag, "_ms_to_es_bus"},   {127'h0, ifc.ms_to_es_bus},   128'h0);
    chk({tag, "_ms_to_ds_bus"},   {89'h0, ifc.ms_to_ds_bus},    128'h0);
  endtask

  initial begin
    reset               = 1'b1;
    ifc.ws_allowin      = 1'b1;
    ifc.es_to_ms_valid  = 1'b0;
    ifc.es_to_ms_bus    = '0;
    ifc.ws_flush        = 1'b0;
    ifc.data_sram_rdata = 32'h0;
    tick;
    tick;
    check_reset_outputs("reset");
    tick;
    reset = 1'b0;

    // Back-to-back ALU ops
    issue(mk_es(0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h5, 32'h0, 32'hBFC00000),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd3, 32'h5, 32'h0, 32'hBFC00000));
    tick;
    issue(mk_es(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h11, 32'h22, 32'hBFC00004),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd4, 32'h11, 32'h22, 32'hBFC00004));
    @(negedge clk);
    chk("b2b_allowin", {127'h0, ifc.ms_allowin}, 128'h1);
    chk("b2b_fwd", {89'h0, ifc.ms_to_ds_bus}, {89'h0, mk_fwd(1, 0, 5'd3, 32'h5)});
    tick;
    idle;
    tick;

    // Load held across a 3-cycle write-back stall
    issue(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd8, 32'h1000, 32'h0, 32'hBFC00008),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd8, 32'hDEADBEEF, 32'h0, 32'hBFC00008));
    tick;
    idle;
    ifc.ws_allowin      = 1'b0;
    ifc.data_sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("stall0_result", {96'h0, ifc.ms_to_ws_bus[95:64]}, {96'h0, 32'hDEADBEEF});
    chk("stall_allowin", {127'h0, ifc.ms_allowin}, 128'h0);
    chk("stall_fwd", {89'h0, ifc.ms_to_ds_bus}, {89'h0, mk_fwd(1, 0, 5'd8, 32'hDEADBEEF)});
    tick;
    ifc.data_sram_rdata = 32'h12345678;
    @(negedge clk);
    chk("stall1_result", {96'h0, ifc.ms_to_ws_bus[95:64]}, {96'h0, 32'hDEADBEEF});
    tick;
    @(negedge clk);
    chk("stall2_result", {96'h0, ifc.ms_to_ws_bus[95:64]}, {96'h0, 32'hDEADBEEF});
    tick;
    ifc.ws_allowin = 1'b1;
    tick;

    // Load with live SRAM data forwarded to decode
    issue(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd8, 32'h2000, 32'h0, 32'hBFC0000C),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd8, 32'h7, 32'h0, 32'hBFC0000C));
    tick;
    idle;
    ifc.data_sram_rdata = 32'h7;
    @(negedge clk);
    chk("load_fwd", {89'h0, ifc.ms_to_ds_bus}, {89'h0, mk_fwd(1, 0, 5'd8, 32'h7)});
    tick;

    // Exception passthrough followed by an mfc0
    issue(mk_es(1, 5'd12, 1, 5'h04, 0, 0, 1, 5'd5, 32'hAA, 32'h0, 32'hBFC00010),
          mk_ws(0, 5'd12, 1, 5'h04, 0, 0, 5'd5, 32'hAA, 32'h0, 32'hBFC00010));
    tick;
    issue(mk_es(0, 5'd14, 0, 0, 1, 0, 1, 5'd9, 32'h33, 32'h0, 32'hBFC00014),
          mk_ws(0, 5'd14, 0, 0, 1, 1, 5'd9, 32'h33, 32'h0, 32'hBFC00014));
    @(negedge clk);
    chk("ex_to_es", {127'h0, ifc.ms_to_es_bus}, 128'h1);
    chk("ex_fwd", {89'h0, ifc.ms_to_ds_bus}, {89'h0, mk_fwd(0, 0, 5'd5, 32'hAA)});
    tick;
    idle;
    @(negedge clk);
    chk("mfc0_to_es", {127'h0, ifc.ms_to_es_bus}, 128'h0);
    chk("mfc0_fwd", {89'h0, ifc.ms_to_ds_bus}, {89'h0, mk_fwd(1, 1, 5'd9, 32'h33)});
    tick;

    // Flush beats a simultaneous accept and drops the held read data
    drive(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd10, 32'h3000, 32'h0, 32'hBFC00018));
    tick;
    idle;
    ifc.ws_allowin      = 1'b0;
    ifc.data_sram_rdata = 32'hCAFE0001;
    tick;
    ifc.ws_flush   = 1'b1;
    ifc.ws_allowin = 1'b1;
    drive(mk_es(0, 0, 0, 0, 0, 0, 1, 5'd13, 32'h44, 32'h0, 32'hBFC0001C));
    tick;
    ifc.ws_flush = 1'b0;
    idle;
    @(negedge clk);
    chk("flush_valid", {127'h0, ifc.ms_to_ws_valid}, 128'h0);
    chk("flush_allowin", {127'h0, ifc.ms_allowin}, 128'h1);
    chk("flush_fwd_we", {127'h0, ifc.ms_to_ds_bus[38]}, 128'h0);
    tick;
    issue(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd11, 32'h4000, 32'h0, 32'hBFC00020),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd11, 32'h600D0001, 32'h0, 32'hBFC00020));
    tick;
    idle;
    ifc.data_sram_rdata = 32'h600D0001;
    tick;

    // Reset in the middle of a stall with rbuf occupied
    drive(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd12, 32'h5000, 32'h0, 32'hBFC00024));
    tick;
    idle;
    ifc.ws_allowin      = 1'b0;
    ifc.data_sram_rdata = 32'hBAD00001;
    tick;
    reset = 1'b1;
    tick;
    check_reset_outputs("midreset");
    tick;
    reset          = 1'b0;
    ifc.ws_allowin = 1'b1;
    issue(mk_es(0, 0, 0, 0, 0, 1, 1, 5'd12, 32'h6000, 32'h0, 32'hBFC00028),
          mk_ws(0, 0, 0, 0, 0, 1, 5'd12, 32'h0000BEEF, 32'h0, 32'hBFC00028));
    tick;
    idle;
    ifc.data_sram_rdata = 32'h0000BEEF;
    tick;
    repeat (3) tick;

    chk("scoreboard_empty", 128'(sb_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
